// File: rtl/ps2_scancode_decoder_if.sv
// ---------------------------------------------------------------------------
// ps2_scancode_decoder_if
//   Key-event stream from the scancode decoder to the display/LED stage.
//   valid/ready handshake; code/ext/rel describe the head event.
//
//   valid  producer -> consumer  head event present
//   ready  consumer -> producer  consumer takes the head event this cycle
//   code   producer -> consumer  8-bit Set-2 key code
//   ext    producer -> consumer  event was E0-prefixed
//   rel    producer -> consumer  event was a break (F0-prefixed)
// ---------------------------------------------------------------------------
interface ps2_scancode_decoder_if;
    logic       valid;
    logic       ready;
    logic [7:0] code;
    logic       ext;
    logic       rel;

    modport master (output valid, code, ext, rel, input ready);
    modport slave  (input valid, code, ext, rel, output ready);
endinterface

// File: rtl/ps2_scancode_decoder.sv
// ---------------------------------------------------------------------------
// ps2_scancode_decoder
//   Assembles PS/2 Set-2 scancode byte sequences into single key events
//   (code + extended + release) and buffers them in a first-word-fall-through
//   FIFO. Reports keyboard self-test replies as one-cycle status pulses and
//   recovers from broken sequences through a prefix timeout and error counter.
//
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   rx_valid    one-cycle pulse: rx_byte/rx_error valid
//   rx_byte     received byte
//   rx_error    byte failed parity/framing check
//   ev          event stream (master side of ps2_scancode_decoder_if)
//   fifo_count  FIFO occupancy, 0..DEPTH
//   overflow    sticky: an event was dropped because the FIFO was full
//   bat_ok      pulse: 0xAA received while idle
//   bat_fail    pulse: 0xFC/0xFD received while idle
//   err_cnt     rx errors plus timeouts, saturating at 255
// ---------------------------------------------------------------------------
module ps2_scancode_decoder #(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_byte,
    input  logic                     rx_error,
    ps2_scancode_decoder_if.master   ev,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     bat_ok,
    output logic                     bat_fail,
    output logic [7:0]               err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_E0,
        ST_F0,
        ST_E0F0,
        ST_PAUSE
    } state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } event_t;

    state_t        state, state_next;
    logic [2:0]    skip, skip_next;        // Pause bytes still to swallow
    logic [TW-1:0] to_cnt, to_next;        // cycles waited inside a prefix
    logic          push;
    event_t        push_ev;
    logic          err_inc;
    logic          bat_ok_next, bat_fail_next;

    // ------------------------------------------------------------------
    // Sequence decoder: next state and event generation
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        skip_next     = skip;
        to_next       = to_cnt;
        push          = 1'b0;
        push_ev       = '0;
        err_inc       = 1'b0;
        bat_ok_next   = 1'b0;
        bat_fail_next = 1'b0;

        if (rx_valid) begin
            to_next = '0;
            if (rx_error) begin
                state_next = ST_IDLE;
                err_inc    = 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        unique case (rx_byte)
                            8'hE0: state_next = ST_E0;
                            8'hF0: state_next = ST_F0;
                            8'hE1: begin
                                state_next = ST_PAUSE;
                                skip_next  = 3'd7;
                            end
                            8'hAA:        bat_ok_next   = 1'b1;
                            8'hFC, 8'hFD: bat_fail_next = 1'b1;
                            // ACK, resend, echo and buffer-error bytes carry no key
                            8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin
                            end
                            default: begin
                                push    = 1'b1;
                                push_ev = '{rx_byte, 1'b0, 1'b0};
                            end
                        endcase
                    end
                    ST_E0: begin
                        if (rx_byte == 8'hF0) begin
                            state_next = ST_E0F0;
                        end else if (rx_byte != 8'hE0) begin
                            push       = 1'b1;
                            push_ev    = '{rx_byte, 1'b1, 1'b0};
                            state_next = ST_IDLE;
                        end
                    end
                    ST_F0: begin
                        if (rx_byte == 8'hE0) begin
                            state_next = ST_E0;
                        end else if (rx_byte != 8'hF0) begin
                            push       = 1'b1;
                            push_ev    = '{rx_byte, 1'b0, 1'b1};
                            state_next = ST_IDLE;
                        end
                    end
                    ST_E0F0: begin
                        if (rx_byte == 8'hE0) begin
                            state_next = ST_E0;
                        end else if (rx_byte != 8'hF0) begin
                            push       = 1'b1;
                            push_ev    = '{rx_byte, 1'b1, 1'b1};
                            state_next = ST_IDLE;
                        end
                    end
                    ST_PAUSE: begin
                        // Pause bytes are counted, not interpreted
                        skip_next = skip - 3'd1;
                        if (skip == 3'd1) begin
                            push       = 1'b1;
                            push_ev    = '{8'hE1, 1'b0, 1'b0};
                            state_next = ST_IDLE;
                        end
                    end
                    default: state_next = ST_IDLE;
                endcase
            end
        end else if (state != ST_IDLE) begin
            if (to_cnt == TO_LAST) begin
                state_next = ST_IDLE;
                err_inc    = 1'b1;
                to_next    = '0;
            end else begin
                to_next = to_cnt + 1'b1;
            end
        end else begin
            to_next = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            skip     <= '0;
            to_cnt   <= '0;
            bat_ok   <= 1'b0;
            bat_fail <= 1'b0;
            err_cnt  <= '0;
        end else begin
            state    <= state_next;
            skip     <= skip_next;
            to_cnt   <= to_next;
            bat_ok   <= bat_ok_next;
            bat_fail <= bat_fail_next;
            if (err_inc && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    event_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, pop, do_push;
    event_t        head;

    assign full    = (fifo_count == FULL_CNT);
    assign pop     = ev.valid && ev.ready;
    // A same-cycle pop frees the slot the push needs
    assign do_push = push && (!full || pop);

    // NOTE: the storage array is not reset; only pointers and count are, and
    // the outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_ev;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

    assign head     = mem[rd_ptr];
    assign ev.valid = (fifo_count != '0);
    assign ev.code  = ev.valid ? head.code : 8'h00;
    assign ev.ext   = ev.valid ? head.ext  : 1'b0;
    assign ev.rel   = ev.valid ? head.rel  : 1'b0;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_scancode_decoder
//   Directed scenarios plus randomized byte streams for ps2_scancode_decoder.
//   Expected behaviour comes from a sequence-level reference model: bytes of
//   the current sequence are collected in a queue and interpreted when the
//   sequence completes; events go to a bounded queue standing in for the FIFO.
// ---------------------------------------------------------------------------
module tb_ps2_scancode_decoder;

    localparam int DEPTH       = 8;
    localparam int TIMEOUT_CYC = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        rx_error;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic        bat_ok;
    logic        bat_fail;
    logic [7:0]  err_cnt;

    ps2_scancode_decoder_if ev_if ();

    ps2_scancode_decoder #(
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .rx_error   (rx_error),
        .ev         (ev_if),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .bat_ok     (bat_ok),
        .bat_fail   (bat_fail),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] pend[$];     // bytes of the sequence in progress
    int         idle_cnt;
    logic       m_ovf;
    int         m_err;
    logic       m_bat_ok, m_bat_fail;

    logic       n_push, n_bat_ok, n_bat_fail;
    ev_t        n_ev;

    task automatic model_reset();
        evq.delete();
        pend.delete();
        idle_cnt   = 0;
        m_ovf      = 1'b0;
        m_err      = 0;
        m_bat_ok   = 1'b0;
        m_bat_fail = 1'b0;
    endtask

    task automatic model_err();
        if (m_err != 255) m_err++;
    endtask

    // Interpret the collected sequence once a byte has been appended.
    task automatic model_byte(input logic [7:0] b);
        int  last_e0;
        logic rel;
        pend.push_back(b);
        if (pend[0] == 8'hE1) begin
            if (pend.size() == 8) begin
                n_push = 1'b1;
                n_ev   = '{8'hE1, 1'b0, 1'b0};
                pend.delete();
            end
        end else if (b == 8'hE0 || b == 8'hF0) begin
            // prefix byte, sequence continues
        end else if (pend.size() == 1) begin
            case (b)
                8'hAA:                             n_bat_ok   = 1'b1;
                8'hFC, 8'hFD:                      n_bat_fail = 1'b1;
                8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
                default: begin
                    n_push = 1'b1;
                    n_ev   = '{b, 1'b0, 1'b0};
                end
            endcase
            pend.delete();
        end else begin
            // E0 anywhere marks extended; a release needs an F0 after the last E0
            last_e0 = -1;
            for (int i = 0; i < pend.size() - 1; i++)
                if (pend[i] == 8'hE0) last_e0 = i;
            rel = 1'b0;
            for (int i = last_e0 + 1; i < pend.size() - 1; i++)
                if (pend[i] == 8'hF0) rel = 1'b1;
            n_push = 1'b1;
            n_ev   = '{b, (last_e0 >= 0), rel};
            pend.delete();
        end
    endtask

    task automatic model_step(input logic v, input logic [7:0] b, input logic e, input logic r);
        logic popping;
        popping    = (evq.size() != 0) && r;
        n_push     = 1'b0;
        n_bat_ok   = 1'b0;
        n_bat_fail = 1'b0;
        if (v) begin
            idle_cnt = 0;
            if (e) begin
                pend.delete();
                model_err();
            end else begin
                model_byte(b);
            end
        end else if (pend.size() != 0) begin
            idle_cnt++;
            if (idle_cnt == TIMEOUT_CYC) begin
                pend.delete();
                idle_cnt = 0;
                model_err();
            end
        end
        if (popping) void'(evq.pop_front());
        if (n_push) begin
            if (evq.size() < DEPTH) evq.push_back(n_ev);
            else                    m_ovf = 1'b1;
        end
        m_bat_ok   = n_bat_ok;
        m_bat_fail = n_bat_fail;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic check_outputs();
        check("ev_valid",   ev_if.valid, (evq.size() != 0));
        check("fifo_count", fifo_count, evq.size());
        if (evq.size() != 0) begin
            check("ev_code", ev_if.code, evq[0].code);
            check("ev_ext",  ev_if.ext,  evq[0].ext);
            check("ev_rel",  ev_if.rel,  evq[0].rel);
        end
        check("overflow", overflow, m_ovf);
        check("err_cnt",  err_cnt,  m_err);
        check("bat_ok",   bat_ok,   m_bat_ok);
        check("bat_fail", bat_fail, m_bat_fail);
    endtask

    // One clock cycle: check current outputs, drive inputs, advance model.
    task automatic step(input logic v, input logic [7:0] b, input logic e, input logic r);
        check_outputs();
        rx_valid    = v;
        rx_byte     = b;
        rx_error    = e;
        ev_if.ready = r;
        model_step(v, b, e, r);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic r);
        step(1'b1, b, 1'b0, r);
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, r);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    logic [7:0] pick_tab [14] = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFC, 8'hFD, 8'hFA,
                                  8'h00, 8'h1C, 8'h75, 8'h14, 8'h77, 8'h16, 8'h5A};
    logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    initial begin
        rx_valid    = 1'b0;
        rx_byte     = 8'h00;
        rx_error    = 1'b0;
        ev_if.ready = 1'b0;
        model_reset();
        do_reset();

        // reset state
        check("rst_valid", ev_if.valid, 1'b0);
        check("rst_count", fifo_count, 4'd0);
        check("rst_code",  ev_if.code, 8'h00);
        check("rst_err",   err_cnt, 8'd0);

        // make then break with consumer ready
        send(8'h1C, 1'b1);
        idle(2, 1'b1);
        send(8'hF0, 1'b1);
        send(8'h1C, 1'b1);
        idle(2, 1'b1);

        // extended break held while consumer stalls, then popped
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h75, 1'b0);
        idle(20, 1'b0);
        check("held_count", fifo_count, 4'd1);
        idle(3, 1'b1);

        // Pause sequence yields one event; following make is normal
        for (int i = 0; i < 8; i++) send(pause_seq[i], 1'b0);
        send(8'h16, 1'b0);
        idle(1, 1'b0);
        check("pause_count", fifo_count, 4'd2);
        idle(4, 1'b1);

        // overflow: 9 makes into 8 entries, then push with same-cycle pop
        for (int i = 0; i < 9; i++) send(8'h15 + 8'(i), 1'b0);
        idle(1, 1'b0);
        check("ovf_count", fifo_count, 4'd8);
        check("ovf_flag",  overflow, 1'b1);
        send(8'h2A, 1'b1);
        idle(1, 1'b0);
        check("ovf_keep8", fifo_count, 4'd8);
        idle(10, 1'b1);

        // rx error mid-sequence, then prefix timeout
        send(8'hE0, 1'b1);
        step(1'b1, 8'h33, 1'b1, 1'b1);
        send(8'h1C, 1'b1);
        idle(2, 1'b1);
        check("err_after_rx", err_cnt, 8'd1);
        send(8'hF0, 1'b1);
        idle(TIMEOUT_CYC + 2, 1'b1);
        check("err_after_to", err_cnt, 8'd2);
        send(8'h1C, 1'b1);
        idle(2, 1'b1);

        // self-test replies
        send(8'hAA, 1'b1);
        send(8'hFC, 1'b1);
        idle(2, 1'b1);

        // randomized byte streams, gaps well below the timeout
        for (int n = 0; n < 600; n++) begin
            int         sel;
            logic [7:0] b;
            int         gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) step(1'b0, 8'h00, 1'b0, 1'($urandom_range(0, 1)));
            sel = $urandom_range(0, 19);
            if (sel < 14) b = pick_tab[sel];
            else          b = 8'($urandom);
            step(1'b1, b, ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
        end
        idle(12, 1'b1);

        // asynchronous reset in the middle of an E0 sequence
        send(8'h1C, 1'b0);
        send(8'hE0, 1'b0);
        rst = 1'b1;
        #1;
        check("arst_valid", ev_if.valid, 1'b0);
        check("arst_count", fifo_count, 4'd0);
        check("arst_ovf",   overflow, 1'b0);
        check("arst_err",   err_cnt, 8'd0);
        check("arst_bat",   {bat_ok, bat_fail}, 2'b00);
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        send(8'h1C, 1'b1);
        idle(2, 1'b1);
        check_outputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Consumes the byte stream from the PS/2 receive stage (one pulse per received 11-bit frame plus its parity/framing error flag) and assembles Set-2 scancode sequences into single key events with make/break and extended attributes. Completed events are buffered in a small first-word-fall-through FIFO with a valid/ready handshake toward the display/LED stage. Keyboard self-test replies are reported as status pulses. A prefix-timeout and error counter recover from broken sequences.

## Interface
- DEPTH, 8: FIFO entries; power of two, 2..64.
- TIMEOUT_CYC, 1000000: CLK cycles a partial prefix sequence may wait for its next byte.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset; asynchronous, active-high.
- RX_VALID  in  1  one-cycle pulse: RX_BYTE/RX_ERROR valid.
- RX_BYTE  in  8  received data byte.
- RX_ERROR  in  1  byte failed parity/start/stop check; sampled with RX_VALID.
- EV_READY  in  1  consumer accepts head event.
- EV_VALID  out  1  FIFO non-empty.
- EV_CODE  out  8  key code of head event.
- EV_EXT  out  1  head event was E0-prefixed.
- EV_REL  out  1  head event was a break (F0-prefixed).
- FIFO_COUNT  out  log2(DEPTH)+1  occupancy.
- OVERFLOW  out  1  sticky: an event was dropped.
- BAT_OK  out  1  one-cycle pulse on 0xAA in IDLE.
- BAT_FAIL  out  1  one-cycle pulse on 0xFC or 0xFD in IDLE.
- ERR_CNT  out  8  count of RX_ERROR bytes plus timeouts; saturates at 255.

## Operation
- Reset: state IDLE, FIFO empty, EV_VALID=0, EV_CODE=0, EV_EXT=0, EV_REL=0, FIFO_COUNT=0, OVERFLOW=0, BAT_OK=0, BAT_FAIL=0, ERR_CNT=0, timeout counter 0.
- Bytes only act in cycles with RX_VALID=1. RX_ERROR=1: byte discarded, state -> IDLE, ERR_CNT+1.
- States: IDLE, E0, F0, E0F0, PAUSE.
- IDLE: 0xE0->E0; 0xF0->F0; 0xE1->PAUSE (skip counter=7); 0xAA->BAT_OK; 0xFC/0xFD->BAT_FAIL; 0xFA, 0xFE, 0xEE, 0x00, 0xFF ignored; any other byte -> push {code,ext=0,rel=0}.
- E0: 0xF0->E0F0; 0xE0 stays; other -> push {code,1,0}, IDLE.
- F0: 0xE0->E0 (restart); 0xF0 stays; other -> push {code,0,1}, IDLE.
- E0F0: 0xE0->E0; 0xF0 stays; other -> push {code,1,1}, IDLE.
- PAUSE: each byte decrements skip counter; byte that reaches 0 pushes {0xE1,0,0} and returns to IDLE. The whole 8-byte Pause sequence yields one event.
- Timeout: counter clears on every RX_VALID and in IDLE. Increments in E0/F0/E0F0/PAUSE. Reaching TIMEOUT_CYC -> IDLE, ERR_CNT+1, no event.
- FIFO: pop when EV_VALID && EV_READY. Push when full without same-cycle pop -> event dropped, OVERFLOW=1 until RST. Push when full with same-cycle pop -> both happen, count stays DEPTH. Push and pop on empty FIFO: push only, since EV_VALID is 0.
- EV_CODE/EV_EXT/EV_REL hold the head entry. They are stable while EV_VALID=1 and not popped. They are don't-care while EV_VALID=0.

## Timing
- Final byte's RX_VALID in cycle N -> entry written at end of N. EV_VALID=1 and fields valid in N+1 if the FIFO was empty.
- Pop at the edge ending cycle M -> next entry visible in M+1. EV_VALID falls in M+1 if the FIFO is then empty.
- BAT_OK/BAT_FAIL are registered: high exactly in cycle N+1 for RX_VALID in N.
- FIFO_COUNT and ERR_CNT update one edge after the causing event.
- Back-to-back RX_VALID on consecutive cycles is fully supported.
- RST mid-sequence or mid-transfer clears everything immediately, with no partial event emitted.

## Test plan
- IDLE, bytes 0x1C, then F0,1C, with EV_READY=1 -> events {1C,0,0} and {1C,0,1}. Each EV_VALID pulse is 1 cycle, one cycle after the final byte.
- Bytes E0,F0,75 with EV_READY=0 -> FIFO_COUNT=1, head {75,1,1} held stable for 20 cycles. Raising EV_READY pops it and EV_VALID falls next cycle.
- E1,14,77,E1,F0,14,F0,77 -> exactly one event {E1,0,0}. BAT_OK stays 0. The following byte 0x16 yields {16,0,0}.
- DEPTH=8, EV_READY=0, 9 make codes -> FIFO_COUNT=8, OVERFLOW=1, 9th lost. A 10th code pushed while EV_READY=1 that cycle -> accepted, count stays 8.
- Byte with RX_ERROR=1 after E0 -> ERR_CNT=1, state IDLE, next 0x1C gives {1C,0,0}. Lone F0 plus TIMEOUT_CYC idle cycles -> ERR_CNT=2, then 0x1C gives {1C,0,0}.
- 0xAA then 0xFC -> one BAT_OK pulse then one BAT_FAIL pulse, no events. Asserting RST mid E0 sequence -> all outputs at reset values.
